// File: rtl/spi_axi_ctrl_if.sv
// AXI4 slave bus bundle for spi_axi_ctrl.
// The master modport is for the SoC interconnect side (or a testbench).
interface spi_axi_ctrl_if #(
    parameter int AXI_WIDTH_ID   = 4,
    parameter int AXI_WIDTH_ADDR = 32,
    parameter int AXI_WIDTH_DATA = 32,
    parameter int AXI_WIDTH_STRB = 4
) ();
    logic [AXI_WIDTH_ID-1:0]   awid;
    logic [AXI_WIDTH_ADDR-1:0] awaddr;
    logic [7:0]                awlen;
    logic [2:0]                awsize;
    logic [1:0]                awburst;
    logic                      awvalid;
    logic                      awready;

    logic [AXI_WIDTH_DATA-1:0] wdata;
    logic [AXI_WIDTH_STRB-1:0] wstrb;
    logic                      wlast;
    logic                      wvalid;
    logic                      wready;

    logic [AXI_WIDTH_ID-1:0]   bid;
    logic [1:0]                bresp;
    logic                      bvalid;
    logic                      bready;

    logic [AXI_WIDTH_ID-1:0]   arid;
    logic [AXI_WIDTH_ADDR-1:0] araddr;
    logic [7:0]                arlen;
    logic [2:0]                arsize;
    logic [1:0]                arburst;
    logic                      arvalid;
    logic                      arready;

    logic [AXI_WIDTH_ID-1:0]   rid;
    logic [AXI_WIDTH_DATA-1:0] rdata;
    logic [1:0]                rresp;
    logic                      rlast;
    logic                      rvalid;
    logic                      rready;

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );
endinterface

// File: rtl/spi_axi_ctrl.sv
// AXI4 register slave driving a mode-0, MSB-first, single-CS SPI master
// for an MFRC522-style reader: 16-bit frames, sticky DONE, debug state export.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | cs_n high, waiting for START
// S_SETUP | cs_n low, MSB on mosi, one half-period before first SCK rise
// S_SHIFT | 16 SCK pulses; rise samples miso, fall drives next mosi bit
// S_HOLD  | cs_n still low for one half-period after the 16th fall
// S_DONE  | single cycle, raises sticky DONE, back to idle
module spi_axi_ctrl #(
    parameter int AXI_WIDTH_ID    = 4,
    parameter int AXI_WIDTH_ADDR  = 32,
    parameter int AXI_WIDTH_DATA  = 32,
    parameter int AXI_WIDTH_STRB  = 4,
    parameter int P_SIZE_IN_BYTES = 4096
) (
    input  logic         axi_aclk,
    input  logic         axi_aresetn,
    spi_axi_ctrl_if.slave s_axi,
    output logic         spi_cs_n,
    output logic         spi_sck,
    output logic         spi_mosi,
    input  logic         spi_miso,
    output logic [2:0]   spi_state_out
);
    localparam int OFF_W = $clog2(P_SIZE_IN_BYTES);
    localparam int IDX_W = OFF_W - 2;
    localparam logic [IDX_W-1:0] IDX_CTRL   = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_STATUS = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_TX     = IDX_W'(2);
    localparam logic [IDX_W-1:0] IDX_RX     = IDX_W'(3);
    localparam logic [IDX_W-1:0] IDX_DIV    = IDX_W'(4);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_HOLD  = 3'd3,
        S_DONE  = 3'd4
    } spi_state_t;

    typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_t;
    typedef enum logic       {RD_IDLE, RD_DATA}          rd_state_t;

    spi_state_t spi_state, spi_next;
    wr_state_t  wr_state, wr_next;
    rd_state_t  rd_state, rd_next;

    logic [15:0]      txdata, rxdata, clkdiv, tx_shift, div_cnt;
    logic [3:0]       bit_cnt;
    logic             done, busy, tc;
    logic [OFF_W-1:0] wr_off, rd_off, rd_off_nxt;
    logic             wr_fixed, rd_fixed;
    logic [7:0]       rd_len, rd_beat;
    logic [IDX_W-1:0] wr_idx;
    logic             aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic             start_go, done_clr;

    assign aw_hs = s_axi.awvalid & s_axi.awready;
    assign w_hs  = s_axi.wvalid  & s_axi.wready;
    assign b_hs  = s_axi.bvalid  & s_axi.bready;
    assign ar_hs = s_axi.arvalid & s_axi.arready;
    assign r_hs  = s_axi.rvalid  & s_axi.rready;

    assign wr_idx     = wr_off[OFF_W-1:2];
    assign rd_off_nxt = rd_fixed ? rd_off : rd_off + OFF_W'(4);
    assign busy       = (spi_state != S_IDLE);
    assign tc         = (div_cnt == 16'd0);
    assign start_go   = w_hs && (wr_idx == IDX_CTRL) && s_axi.wstrb[0]
                        && s_axi.wdata[0] && (spi_state == S_IDLE);
    assign done_clr   = w_hs && (wr_idx == IDX_STATUS) && s_axi.wstrb[0]
                        && s_axi.wdata[1];

    assign s_axi.bresp = 2'b00;
    assign s_axi.rresp = 2'b00;
    assign spi_state_out = spi_state;

    logic unused_ok;
    assign unused_ok = ^{s_axi.awlen, s_axi.awsize, s_axi.arsize,
                         s_axi.awaddr, s_axi.araddr, s_axi.wdata, s_axi.wstrb};

    function automatic logic [31:0] reg_read(input logic [IDX_W-1:0] idx);
        logic [31:0] v;
        v = '0;
        case (idx)
            IDX_STATUS: v = {27'd0, spi_state, done, busy};
            IDX_TX:     v = {16'd0, txdata};
            IDX_RX:     v = {16'd0, rxdata};
            IDX_DIV:    v = {16'd0, clkdiv};
            default:    v = '0;
        endcase
        return v;
    endfunction

    // ---------------- write channel ----------------
    always_comb begin
        wr_next = wr_state;
        case (wr_state)
            WR_IDLE: if (aw_hs)                 wr_next = WR_DATA;
            WR_DATA: if (w_hs && s_axi.wlast)   wr_next = WR_RESP;
            WR_RESP: if (b_hs)                  wr_next = WR_IDLE;
            default:                            wr_next = WR_IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            wr_state      <= WR_IDLE;
            s_axi.awready <= 1'b0;
            s_axi.wready  <= 1'b0;
            s_axi.bvalid  <= 1'b0;
            s_axi.bid     <= '0;
            wr_off        <= '0;
            wr_fixed      <= 1'b0;
        end else begin
            wr_state      <= wr_next;
            s_axi.awready <= (wr_next == WR_IDLE);
            s_axi.wready  <= (wr_next == WR_DATA);
            s_axi.bvalid  <= (wr_next == WR_RESP);
            if (aw_hs) begin
                s_axi.bid <= s_axi.awid;
                wr_off    <= s_axi.awaddr[OFF_W-1:0];
                wr_fixed  <= (s_axi.awburst == 2'b00);
            end else if (w_hs && !wr_fixed) begin
                wr_off <= wr_off + OFF_W'(4);
            end
        end
    end

    // ---------------- read channel ----------------
    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            RD_IDLE: if (ar_hs)                 rd_next = RD_DATA;
            RD_DATA: if (r_hs && s_axi.rlast)   rd_next = RD_IDLE;
            default:                            rd_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            rd_state      <= RD_IDLE;
            s_axi.arready <= 1'b0;
            s_axi.rvalid  <= 1'b0;
            s_axi.rlast   <= 1'b0;
            s_axi.rid     <= '0;
            s_axi.rdata   <= '0;
            rd_off        <= '0;
            rd_fixed      <= 1'b0;
            rd_len        <= '0;
            rd_beat       <= '0;
        end else begin
            rd_state      <= rd_next;
            s_axi.arready <= (rd_next == RD_IDLE);
            s_axi.rvalid  <= (rd_next == RD_DATA);
            if (ar_hs) begin
                s_axi.rid   <= s_axi.arid;
                rd_off      <= s_axi.araddr[OFF_W-1:0];
                rd_fixed    <= (s_axi.arburst == 2'b00);
                rd_len      <= s_axi.arlen;
                rd_beat     <= 8'd0;
                s_axi.rdata <= reg_read(s_axi.araddr[OFF_W-1:2]);
                s_axi.rlast <= (s_axi.arlen == 8'd0);
            end else if (r_hs && !s_axi.rlast) begin
                rd_off      <= rd_off_nxt;
                rd_beat     <= rd_beat + 8'd1;
                s_axi.rdata <= reg_read(rd_off_nxt[OFF_W-1:2]);
                s_axi.rlast <= ((rd_beat + 8'd1) == rd_len);
            end
        end
    end

    // ---------------- configuration registers ----------------
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            txdata <= 16'h0000;
            clkdiv <= 16'd4;
            done   <= 1'b0;
        end else begin
            if (w_hs && wr_idx == IDX_TX) begin
                if (s_axi.wstrb[0]) txdata[7:0]  <= s_axi.wdata[7:0];
                if (s_axi.wstrb[1]) txdata[15:8] <= s_axi.wdata[15:8];
            end
            if (w_hs && wr_idx == IDX_DIV) begin
                if (s_axi.wstrb[0]) clkdiv[7:0]  <= s_axi.wdata[7:0];
                if (s_axi.wstrb[1]) clkdiv[15:8] <= s_axi.wdata[15:8];
            end
            // FSM completion outranks a software clear in the same cycle
            if (spi_next == S_DONE)         done <= 1'b1;
            else if (start_go || done_clr)  done <= 1'b0;
        end
    end

    // ---------------- SPI FSM ----------------
    always_comb begin
        spi_next = spi_state;
        case (spi_state)
            S_IDLE:  if (start_go)                              spi_next = S_SETUP;
            S_SETUP: if (tc)                                    spi_next = S_SHIFT;
            S_SHIFT: if (tc && spi_sck && bit_cnt == 4'd15)     spi_next = S_HOLD;
            S_HOLD:  if (tc)                                    spi_next = S_DONE;
            S_DONE:                                             spi_next = S_IDLE;
            default:                                            spi_next = S_IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            spi_state <= S_IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            tx_shift  <= '0;
            rxdata    <= '0;
            spi_cs_n  <= 1'b1;
            spi_sck   <= 1'b0;
            spi_mosi  <= 1'b0;
        end else begin
            spi_state <= spi_next;
            case (spi_state)
                S_IDLE: begin
                    if (start_go) begin
                        tx_shift <= txdata;
                        spi_mosi <= txdata[15];
                        spi_cs_n <= 1'b0;
                        div_cnt  <= clkdiv;
                        bit_cnt  <= 4'd0;
                    end
                end
                S_SETUP, S_HOLD: begin
                    if (tc) begin
                        div_cnt <= clkdiv;
                        if (spi_state == S_HOLD) spi_cs_n <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt - 16'd1;
                    end
                end
                S_SHIFT: begin
                    if (tc) begin
                        div_cnt <= clkdiv;
                        if (!spi_sck) begin
                            spi_sck <= 1'b1;
                            rxdata  <= {rxdata[14:0], spi_miso};
                        end else begin
                            // zeros shift in, so mosi returns low after the last bit
                            spi_sck  <= 1'b0;
                            bit_cnt  <= bit_cnt + 4'd1;
                            tx_shift <= {tx_shift[14:0], 1'b0};
                            spi_mosi <= tx_shift[14];
                        end
                    end else begin
                        div_cnt <= div_cnt - 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_axi_ctrl.sv
// Self-checking bench for spi_axi_ctrl with a small MFRC522 SPI responder.
module tb_spi_axi_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       spi_cs_n, spi_sck, spi_mosi;
    logic       spi_miso = 1'b0;
    logic [2:0] spi_state_out;

    spi_axi_ctrl_if axi ();

    spi_axi_ctrl dut (
        .axi_aclk      (clk),
        .axi_aresetn   (rst_n),
        .s_axi         (axi),
        .spi_cs_n      (spi_cs_n),
        .spi_sck       (spi_sck),
        .spi_mosi      (spi_mosi),
        .spi_miso      (spi_miso),
        .spi_state_out (spi_state_out)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // ---------------- MFRC522 responder ----------------
    logic [7:0]  mf_regs [64] = '{default: 8'h00};
    logic [15:0] mosi_cap = 16'h0;
    int          sck_total = 0;
    int          sck_at_cs = 0;
    int          mf_k = 0;
    logic [7:0]  mf_resp = 8'h00;

    function automatic logic [7:0] mf_read(input logic [5:0] a);
        return (a == 6'h37) ? 8'h92 : mf_regs[a];
    endfunction

    always @(posedge spi_sck) begin
        mosi_cap  <= {mosi_cap[14:0], spi_mosi};
        sck_total <= sck_total + 1;
    end

    always @(negedge spi_sck) begin
        mf_k = sck_total - sck_at_cs;
        if (mf_k == 8) mf_resp = mosi_cap[7] ? mf_read(mosi_cap[6:1]) : 8'h00;
        if (mf_k >= 8 && mf_k < 16) spi_miso = mf_resp[15-mf_k];
        else                        spi_miso = 1'b0;
    end

    always @(spi_cs_n) begin
        if (spi_cs_n === 1'b0) sck_at_cs = sck_total;
        else if (spi_cs_n === 1'b1 && (sck_total - sck_at_cs) == 16 && !mosi_cap[15])
            mf_regs[mosi_cap[14:9]] = mosi_cap[7:0];
    end

    // ---------------- transfer length monitor ----------------
    int         cyc = 0;
    int         setup_cyc = 0;
    int         xfer_len = 0;
    logic [2:0] prev_state = 3'd0;
    always @(negedge clk) begin
        cyc <= cyc + 1;
        prev_state <= spi_state_out;
        if (spi_state_out == 3'd1 && prev_state != 3'd1) setup_cyc <= cyc;
        if (spi_state_out == 3'd4 && prev_state != 3'd4) xfer_len <= cyc - setup_cyc;
    end

    // ---------------- AXI master tasks ----------------
    logic [31:0] wbuf [8];
    logic [31:0] rbuf [8];
    logic        rlast_buf [8];
    logic [3:0]  rid_seen, bid_seen;
    logic [1:0]  resp_seen;

    task automatic axi_wr(input logic [31:0] addr, input int len, input logic [1:0] burst,
                          input logic [3:0] id, input logic [3:0] strb);
        int g;
        @(negedge clk);
        axi.awid = id; axi.awaddr = addr; axi.awlen = 8'(len);
        axi.awsize = 3'd2; axi.awburst = burst; axi.awvalid = 1'b1;
        g = 0;
        while (!axi.awready && g < 50) begin @(negedge clk); g++; end
        if (!axi.awready) chk("awready_timeout", 32'(axi.awready), 32'd1);
        @(negedge clk);
        axi.awvalid = 1'b0;
        for (int b = 0; b <= len; b++) begin
            axi.wdata = wbuf[b]; axi.wstrb = strb; axi.wlast = (b == len); axi.wvalid = 1'b1;
            g = 0;
            while (!axi.wready && g < 50) begin @(negedge clk); g++; end
            if (!axi.wready) chk("wready_timeout", 32'(axi.wready), 32'd1);
            @(negedge clk);
        end
        axi.wvalid = 1'b0; axi.wlast = 1'b0; axi.bready = 1'b1;
        g = 0;
        while (!axi.bvalid && g < 50) begin @(negedge clk); g++; end
        if (!axi.bvalid) chk("bvalid_timeout", 32'(axi.bvalid), 32'd1);
        bid_seen = axi.bid; resp_seen = axi.bresp;
        @(negedge clk);
        axi.bready = 1'b0;
    endtask

    task automatic axi_rd(input logic [31:0] addr, input int len, input logic [1:0] burst,
                          input logic [3:0] id);
        int g;
        @(negedge clk);
        axi.arid = id; axi.araddr = addr; axi.arlen = 8'(len);
        axi.arsize = 3'd2; axi.arburst = burst; axi.arvalid = 1'b1;
        g = 0;
        while (!axi.arready && g < 50) begin @(negedge clk); g++; end
        if (!axi.arready) chk("arready_timeout", 32'(axi.arready), 32'd1);
        @(negedge clk);
        axi.arvalid = 1'b0; axi.rready = 1'b1;
        for (int b = 0; b <= len; b++) begin
            g = 0;
            while (!axi.rvalid && g < 50) begin @(negedge clk); g++; end
            if (!axi.rvalid) chk("rvalid_timeout", 32'(axi.rvalid), 32'd1);
            rbuf[b] = axi.rdata; rlast_buf[b] = axi.rlast;
            rid_seen = axi.rid; resp_seen = axi.rresp;
            @(negedge clk);
        end
        axi.rready = 1'b0;
    endtask

    task automatic wr32(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] strb);
        wbuf[0] = d;
        axi_wr(addr, 0, 2'b01, 4'h0, strb);
    endtask

    task automatic rd32(input logic [31:0] addr, output logic [31:0] d);
        axi_rd(addr, 0, 2'b01, 4'h0);
        d = rbuf[0];
    endtask

    task automatic poll_done(input string nm);
        logic [31:0] st;
        int g;
        st = 32'h0; g = 0;
        while (!st[1] && g < 100) begin rd32(32'h04, st); g++; end
        if (!st[1]) chk({nm, "_done_timeout"}, st, 32'h2);
    endtask

    // Runs one frame and checks pulse count, MOSI bits, RXDATA, length, idle state.
    task automatic run_frame(input string nm, input logic [15:0] frame,
                             input logic [31:0] exp_rx, input int exp_len);
        int base;
        logic [31:0] d;
        wr32(32'h08, {16'h0, frame}, 4'hF);
        base = sck_total;
        wr32(32'h00, 32'h1, 4'hF);
        poll_done(nm);
        chk({nm, "_sck_pulses"}, 32'(sck_total - base), 32'd16);
        chk({nm, "_mosi"}, {16'h0, mosi_cap}, {16'h0, frame});
        chk({nm, "_len"}, 32'(xfer_len), 32'(exp_len));
        rd32(32'h0C, d);
        chk({nm, "_rxdata"}, d, exp_rx);
        chk({nm, "_cs_n"}, 32'(spi_cs_n), 32'd1);
        rd32(32'h04, d);
        chk({nm, "_status"}, d, 32'h2);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        do_wr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [13];

    initial begin
        #400us;
        $display("FAIL watchdog: bench time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int base;

        axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0; axi.awburst = '0;
        axi.awvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0;
        axi.bready = 1'b0; axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = '0;
        axi.arburst = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;

        vecs[0]  = '{32'h10,   1'b0, 32'h0,        4'hF, 32'h4};
        vecs[1]  = '{32'h08,   1'b0, 32'h0,        4'hF, 32'h0};
        vecs[2]  = '{32'h08,   1'b1, 32'h0000A5C3, 4'hF, 32'h0000A5C3};
        vecs[3]  = '{32'h10,   1'b1, 32'h2,        4'hF, 32'h2};
        vecs[4]  = '{32'h80,   1'b1, 32'hFFFFFFFF, 4'hF, 32'h0};
        vecs[5]  = '{32'h00,   1'b1, 32'h0,        4'hF, 32'h0};
        vecs[6]  = '{32'h0C,   1'b1, 32'h0000FFFF, 4'hF, 32'h0};
        vecs[7]  = '{32'h08,   1'b1, 32'h000000FF, 4'h1, 32'h0000A5FF};
        vecs[8]  = '{32'h08,   1'b1, 32'h00001200, 4'h2, 32'h000012FF};
        vecs[9]  = '{32'h08,   1'b1, 32'hFFFFA5C3, 4'hF, 32'h0000A5C3};
        vecs[10] = '{32'h04,   1'b0, 32'h0,        4'hF, 32'h0};
        vecs[11] = '{32'h1010, 1'b1, 32'h3,        4'hF, 32'h3};
        vecs[12] = '{32'h10,   1'b1, 32'h2,        4'hF, 32'h2};

        // reset state while aresetn is held low
        #100;
        chk("rst_cs_n",    32'(spi_cs_n),      32'd1);
        chk("rst_sck",     32'(spi_sck),       32'd0);
        chk("rst_state",   32'(spi_state_out), 32'd0);
        chk("rst_valids",  {28'h0, axi.awready, axi.arready, axi.bvalid, axi.rvalid}, 32'h0);
        #24 rst_n = 1'b1;
        rd32(32'h04, d);
        chk("rst_status", d, 32'h0);

        for (int i = 0; i < 13; i++) begin
            if (vecs[i].do_wr) wr32(vecs[i].addr, vecs[i].wdata, vecs[i].strb);
            rd32(vecs[i].addr, d);
            chk($sformatf("regvec%0d", i), d, vecs[i].exp);
        end

        // CLKDIV=2: half-period 3 cycles, 34 half-periods
        run_frame("version", 16'hEE00, 32'h0092, 102);
        run_frame("wr_reg15", 16'h2A55, 32'h0000, 102);
        run_frame("rd_reg15", 16'hAA00, 32'h0055, 102);

        // START while busy is ignored; TXDATA update only used next time
        wr32(32'h08, 32'hEE00, 4'hF);
        base = sck_total;
        wr32(32'h00, 32'h1, 4'hF);
        repeat (20) @(negedge clk);
        rd32(32'h04, d);
        chk("busy_bit", {31'h0, d[0]}, 32'h1);
        wr32(32'h08, 32'h1234, 4'hF);
        wr32(32'h00, 32'h1, 4'hF);
        poll_done("busy");
        chk("busy_sck_pulses", 32'(sck_total - base), 32'd16);
        chk("busy_mosi", {16'h0, mosi_cap}, 32'hEE00);
        chk("busy_len", 32'(xfer_len), 32'd102);
        rd32(32'h08, d);
        chk("busy_txdata", d, 32'h1234);
        wr32(32'h04, 32'h2, 4'hF);
        rd32(32'h04, d);
        chk("done_clear", d, 32'h0);

        // fastest divider
        wr32(32'h10, 32'h0, 4'hF);
        run_frame("div0", 16'hEE00, 32'h0092, 34);

        // INCR write burst across CTRL/STATUS/TXDATA/RXDATA
        wbuf[0] = 32'h0; wbuf[1] = 32'h0; wbuf[2] = 32'h0000BEEF; wbuf[3] = 32'h3;
        axi_wr(32'h00, 3, 2'b01, 4'h5, 4'hF);
        chk("burst_bid",   {28'h0, bid_seen}, 32'h5);
        chk("burst_bresp", {30'h0, resp_seen}, 32'h0);
        axi_rd(32'h08, 3, 2'b01, 4'h9);
        chk("burst_r0", rbuf[0], 32'hBEEF);
        chk("burst_r1", rbuf[1], 32'h0092);
        chk("burst_r2", rbuf[2], 32'h0);
        chk("burst_r3", rbuf[3], 32'h0);
        chk("burst_rlast", {28'h0, rlast_buf[3], rlast_buf[2], rlast_buf[1], rlast_buf[0]}, 32'h8);
        chk("burst_rid", {28'h0, rid_seen}, 32'h9);
        chk("burst_rresp", {30'h0, resp_seen}, 32'h0);
        axi_rd(32'h08, 1, 2'b00, 4'h3);
        chk("fixed_r0", rbuf[0], 32'hBEEF);
        chk("fixed_r1", rbuf[1], 32'hBEEF);
        chk("fixed_rlast", {30'h0, rlast_buf[1], rlast_buf[0]}, 32'h2);

        // reset in the middle of a shift aborts at once
        wr32(32'h10, 32'h2, 4'hF);
        wr32(32'h00, 32'h1, 4'hF);
        repeat (40) @(negedge clk);
        chk("mid_state_shift", 32'(spi_state_out), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_cs_n",  32'(spi_cs_n),      32'd1);
        chk("abort_sck",   32'(spi_sck),       32'd0);
        chk("abort_mosi",  32'(spi_mosi),      32'd0);
        chk("abort_state", 32'(spi_state_out), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rd32(32'h08, d);
        chk("abort_txdata", d, 32'h0);
        rd32(32'h10, d);
        chk("abort_clkdiv", d, 32'h4);
        rd32(32'h04, d);
        chk("abort_status", d, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/spi_axi_ctrl.md
# spi_axi_ctrl

AXI4 memory-mapped slave that drives a single-chip-select SPI master (mode 0, MSB first), used to access an MFRC522-style RFID reader from the RISC-V SoC. Software loads a 16-bit frame (address byte + data byte), starts the transfer, polls for completion and reads back the captured MISO bits. The current SPI FSM state is also exported for debug.

## Interface
- AXI_WIDTH_ID, 4, width of AXI ID fields
- AXI_WIDTH_ADDR, 32, AXI address width
- AXI_WIDTH_DATA, 32, AXI data width (only 32 supported)
- AXI_WIDTH_STRB, 4, write-strobe width
- P_SIZE_IN_BYTES, 4096, decoded window; offset = addr mod P_SIZE_IN_BYTES
- axi_aclk  in  1  single clock
- axi_aresetn  in  1  reset, asynchronous, active-low
- s_axi_aw{id,addr,len,size,burst,valid}/awready  AXI4 write-address channel
- s_axi_w{data,strb,last,valid}/wready  AXI4 write-data channel
- s_axi_b{id,resp,valid}/bready  AXI4 write-response channel
- s_axi_ar{id,addr,len,size,burst,valid}/arready  AXI4 read-address channel
- s_axi_r{id,data,resp,last,valid}/rready  AXI4 read-data channel
- spi_cs_n  out  1  chip select, active-low
- spi_sck  out  1  SPI clock, idles low
- spi_mosi  out  1  serial out
- spi_miso  in  1  serial in
- spi_state_out  out  3  current SPI FSM state encoding

## Operation
- Register map (offset[11:2], word access; byte strobes honoured):
  - 0x00 CTRL: bit0 START, write-1 pulse, reads 0.
  - 0x04 STATUS (RO except bit1): bit0 BUSY, bit1 DONE (sticky; write 1 clears), bits[4:2] FSM state.
  - 0x08 TXDATA [15:0]: frame; [15:8] sent first. Reset 0.
  - 0x0C RXDATA [15:0] (RO): MISO bits captured, same order; [7:0] = returned data byte.
  - 0x10 CLKDIV [15:0]: half-period = CLKDIV+1 aclk cycles. Reset 4 (SCK = aclk/10). Value 0 legal (aclk/2).
  - Other offsets: reads 0, writes ignored, resp OKAY.
- MFRC522 frame convention (software): byte0 = {R/W̄, addr[5:0], 0}; read 0x37 → 0xEE.
- SPI FSM: IDLE(0) → SETUP(1) → SHIFT(2) → HOLD(3) → DONE(4) → IDLE.
  - START in IDLE: load shifter, clear DONE, cs_n=0, mosi=bit15 → SETUP.
  - SETUP: wait one half-period → SHIFT.
  - SHIFT: 16 SCK pulses; rising edge samples miso into RXDATA LSB (shift left); falling edge drives next bit.
  - HOLD: after 16th falling edge, keep cs_n low one half-period, then cs_n=1.
  - DONE: one cycle, set DONE → IDLE.
- START while BUSY (state≠0) is ignored; TXDATA writes during BUSY take effect on the next START.
- AXI: bursts INCR/FIXED, len 0–255; INCR advances offset by 4 per beat. bid=awid, rid=arid, resp always OKAY. One write and one read transaction may be in flight simultaneously; register write and STATUS DONE-clear in the same cycle as FSM set: FSM set wins.

## Timing
- Reset (async assert): all valid/ready outputs 0, bresp/rresp/rdata 0, cs_n=1, sck=0, mosi=0, spi_state_out=0, registers to reset values; an active transfer aborts immediately.
- awready=1 in write-idle; after AW handshake, wready=1 until the beat with wlast; bvalid asserted the cycle after the last W handshake, held until bready.
- arready=1 in read-idle; rvalid the cycle after AR handshake (registered rdata), next beat the cycle after each R handshake; rlast on beat len.
- START write to FSM SETUP: 1 cycle after W handshake.
- Transfer length: (CLKDIV+1) × 34 aclk cycles from SETUP entry to DONE entry, plus 1 DONE cycle.
- spi_state_out and STATUS are registered and match the FSM each cycle.

## Test plan
- Reset: hold aresetn low 124 ns → cs_n=1, sck=0, all AXI valids 0, STATUS reads 0x0.
- Register R/W: write TXDATA=0xA5C3, CLKDIV=2 → read back 0x0000A5C3, 0x00000002; unmapped 0x80 reads 0.
- Read VersionReg: TXDATA=0xEE00, START → 16 SCK pulses, MOSI 0xEE,0x00; companion MFRC522 model returns 0x92; poll DONE → RXDATA[7:0]=0x92, cs_n high.
- Write then read back: frame 0x2A55 (write reg 0x15=0x55), then 0xAA00 → RXDATA[7:0]=0x55.
- START while BUSY: second START mid-shift ignored; exactly 16 SCK pulses; DONE write-1 clears to 0.
- Burst: INCR awlen=3 at 0x00..0x0C → single bresp OKAY; arlen=3 → 4 beats, rlast only on 4th; reset mid-transfer → cs_n=1 immediately, state 0.
